// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin owner arbitration in front of a single UART byte
// transmitter. An owner keeps the line until its packet's last byte has been
// shifted out, or until it stalls mid-packet for HOLD_TIMEOUT cycles.
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 abort
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, GUARD, WAIT, HOLD} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [IW-1:0]   gid, gid_n;
    logic [IW-1:0]   pick, sel;
    logic            found;
    int              idx;
    logic            last_r, last_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] ack_n;
    logic            tx_start_n, gv_n, abort_n;
    logic [7:0]      tx_data_n;

    assign grant_id = 3'(gid);

    // Round-robin pick: first set req bit after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        gid_n      = gid;
        gv_n       = grant_valid;
        last_n     = last_r;
        cnt_n      = cnt;
        ack_n      = '0;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        abort_n    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gid_n   = pick;
                    gv_n    = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = req_data[{gid, 3'b000} +: 8];
                    ack_n[gid] = 1'b1;
                    last_n     = req_last[gid];
                    state_n    = GUARD;
                end
            end
            // tx_busy only rises the cycle after tx_start, so skip one look.
            GUARD: state_n = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (last_r) begin
                        rr_ptr_n = gid;
                        gv_n     = 1'b0;
                        state_n  = IDLE;
                    end else if (req[gid]) begin
                        state_n = LAUNCH;
                    end else begin
                        cnt_n   = '0;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req[gid]) begin
                    state_n = LAUNCH;
                end else if (cnt == CW'(HOLD_TIMEOUT - 1)) begin
                    abort_n  = 1'b1;
                    rr_ptr_n = gid;
                    gv_n     = 1'b0;
                    state_n  = IDLE;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IW'(NUM_REQ - 1);
            gid         <= '0;
            grant_valid <= 1'b0;
            last_r      <= 1'b0;
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            abort       <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            gid         <= gid_n;
            grant_valid <= gv_n;
            last_r      <= last_n;
            cnt         <= cnt_n;
            ack         <= ack_n;
            tx_start    <= tx_start_n;
            tx_data     <= tx_data_n;
            abort       <= abort_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues, a transmitter model and a
// scoreboard of expected (owner, byte) launches in order.
module tb_uart_tx_arb;
    localparam int NREQ     = 4;
    localparam int BUSY_LEN = 5;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         last;
    } vec_t;
    typedef logic [8:0] rq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   ack;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              grant_valid;
    logic [2:0]        grant_id;
    logic              abort;

    uart_tx_arb #(.NUM_REQ(NREQ), .HOLD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_valid(grant_valid),
        .grant_id(grant_id), .abort(abort)
    );

    always #5 clk = ~clk;

    vec_t tv[20];
    vec_t sb[$];
    vec_t e;
    rq_t  rq[NREQ];
    int   checks = 0, errors = 0;
    int   cyc = 0, fall_cyc = 0, busy_cnt = 0;
    bit   start_d = 0, force_busy = 0;
    int   ack_bad = 0, abort_cnt = 0, abort_gap = 0, start_cnt = 0;
    logic abort_gv = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]       = rq[i][0][8];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // Loads table rows [s,e) into requester queues and the scoreboard.
    task automatic load_group(input int s, input int en);
        @(posedge clk); #2;
        for (int k = s; k < en; k++) begin
            rq[tv[k].id].push_back({tv[k].last, tv[k].data});
            sb.push_back(tv[k]);
        end
        update_reqs();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(sb.size() == 0 && !grant_valid && !tx_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s: timeout, %0d launches still expected", name, sb.size());
        end
    endtask

    // Transmitter model (busy rises the cycle after tx_start) and requesters.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) fall_cyc = cyc;
            end
            if (start_d) busy_cnt = BUSY_LEN;
            start_d = tx_start;
            tx_busy = force_busy || (busy_cnt > 0);
            for (int i = 0; i < NREQ; i++)
                if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            update_reqs();
        end
    end

    // Output monitor: scoreboard pops on each launch.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack != '0 && !tx_start) ack_bad++;
            if (tx_start) begin
                start_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got data %0h ack %0h, expected no launch", tx_data, ack);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("ack", 32'(ack), 32'(1) << e.id);
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("grant_valid", 32'(grant_valid), 32'd1);
                end
            end
            if (abort) begin
                abort_cnt++;
                abort_gap = cyc - fall_cyc;
                abort_gv  = grant_valid;
            end
        end
    end

    initial begin
        int sc;
        tv = '{
            '{1, 8'h11, 1}, '{3, 8'h33, 1},
            '{1, 8'h5A, 1},
            '{2, 8'hA0, 0}, '{2, 8'hA1, 0}, '{2, 8'hA2, 1}, '{0, 8'h0C, 1},
            '{3, 8'h3F, 1},
            '{0, 8'h40, 1}, '{1, 8'h41, 1}, '{2, 8'h42, 1}, '{3, 8'h43, 1}, '{0, 8'h44, 1},
            '{1, 8'h71, 0}, '{2, 8'h72, 1},
            '{0, 8'h5C, 1},
            '{2, 8'hB0, 0},
            '{0, 8'hC0, 1}, '{2, 8'hB1, 0}, '{2, 8'hB2, 1}
        };

        repeat (2) @(posedge clk);
        #2;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_abort", 32'(abort), 0);
        rst = 1'b0;

        // Straight table groups: 1-byte pair, rr prep, multi-byte owner,
        // rr prep, all four requesting.
        begin
            int gs[6] = '{0, 2, 3, 7, 8, 13};
            for (int g = 0; g < 5; g++) begin
                load_group(gs[g], gs[g+1]);
                wait_done($sformatf("group%0d", g));
            end
        end

        // Owner 1 stalls after a non-last byte; requester 2 pending.
        abort_cnt = 0;
        load_group(13, 15);
        wait_done("timeout_group");
        check("abort_count", 32'(abort_cnt), 1);
        check("abort_gap", 32'(abort_gap), 9);
        check("abort_gv", 32'(abort_gv), 0);

        // Transmitter busy for 20 cycles while requester 0 waits in LAUNCH.
        @(posedge clk); #2;
        force_busy = 1'b1;
        tx_busy    = 1'b1;
        sc = start_cnt;
        load_group(15, 16);
        repeat (20) @(negedge clk);
        check("stall_no_start", 32'(start_cnt - sc), 0);
        check("stall_grant_valid", 32'(grant_valid), 1);
        @(posedge clk); #2;
        force_busy = 1'b0;
        tx_busy    = (busy_cnt > 0);
        wait_done("stall_group");
        check("stall_one_start", 32'(start_cnt - sc), 1);

        // Reset in WAIT of a multi-byte packet from requester 2.
        load_group(16, 17);
        begin
            int n = 0;
            while (!tx_busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("reset_reach_wait", 32'(n < 200), 1);
        end
        @(posedge clk); #2;
        check("pre_rst_grant_valid", 32'(grant_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 0);
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_grant_valid", 32'(grant_valid), 0);
        check("mid_rst_grant_id", 32'(grant_id), 0);
        check("mid_rst_abort", 32'(abort), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        load_group(17, 20);
        wait_done("post_reset_group");

        check("abort_total", 32'(abort_cnt), 1);
        check("ack_without_start", 32'(ack_bad), 0);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
